// File: rtl/tune_pkg.sv
// rtl/tune_pkg.sv - shared FSM encoding, entry layout and constants for the tune sequencer
package tune_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_t;

  localparam logic [7:0] TUNE_REST = 8'h00;
  localparam logic [7:0] END_BEATS = 8'h00;

  localparam int TUNE_MSB  = 15;
  localparam int TUNE_LSB  = 8;
  localparam int BEATS_MSB = 7;
  localparam int BEATS_LSB = 0;

  // Bits needed to hold max(a, b) - 1, never less than one.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/tune_beat_timer.sv
// rtl/tune_beat_timer.sv - beats x period down-counter with a single-cycle terminal-count pulse
module tune_beat_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [7:0]    load_beats,
  input  logic [CW-1:0] load_period,
  output logic          tc
);

  logic          run_q, run_d;
  logic [7:0]    beat_q, beat_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] period_q, period_d;

  // tc marks the last cycle of the loaded interval
  assign tc = run_q && (cyc_q == '0) && (beat_q == 8'd0);

  always_comb begin
    run_d    = run_q;
    beat_d   = beat_q;
    cyc_d    = cyc_q;
    period_d = period_q;
    if (clr) begin
      run_d    = 1'b0;
      beat_d   = 8'd0;
      cyc_d    = '0;
      period_d = '0;
    end else if (load) begin
      run_d    = |load_beats;
      beat_d   = load_beats - 8'd1;
      cyc_d    = load_period;
      period_d = load_period;
    end else if (run_q) begin
      if (cyc_q == '0) begin
        if (beat_q == 8'd0) begin
          run_d = 1'b0;
        end else begin
          beat_d = beat_q - 8'd1;
          cyc_d  = period_q;
        end
      end else begin
        cyc_d = cyc_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      beat_q   <= 8'd0;
      cyc_q    <= '0;
      period_q <= '0;
    end else begin
      run_q    <= run_d;
      beat_q   <= beat_d;
      cyc_q    <= cyc_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/tune_sequencer.sv
// rtl/tune_sequencer.sv - walks a note ROM, holding each tune code for its beats then a short gap
module tune_sequencer
  import tune_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int BEAT_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        tune,
  output logic              busy,
  output logic              note_strobe,
  output logic              done
);

  localparam int CW = cnt_width(BEAT_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] BEAT_LD = CW'(BEAT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tune_q, tune_d;
  logic              strobe_q, strobe_d;
  logic              done_q, done_d;
  logic              last_q, last_d;

  logic              tmr_clr, tmr_load, tmr_tc;
  logic [7:0]        tmr_beats;
  logic [CW-1:0]     tmr_period;

  logic [7:0]        entry_tune, entry_beats;

  assign entry_tune  = rom_data[TUNE_MSB:TUNE_LSB];
  assign entry_beats = rom_data[BEATS_MSB:BEATS_LSB];

  assign rom_addr    = addr_q;
  assign tune        = tune_q;
  assign busy        = (state_q != S_IDLE);
  assign note_strobe = strobe_q;
  assign done        = done_q;

  tune_beat_timer #(.CW(CW)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (tmr_clr),
    .load        (tmr_load),
    .load_beats  (tmr_beats),
    .load_period (tmr_period),
    .tc          (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tune_d     = tune_q;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    last_d     = last_q;
    tmr_clr    = 1'b0;
    tmr_load   = 1'b0;
    tmr_beats  = entry_beats;
    tmr_period = BEAT_LD;

    if (stop) begin
      state_d = S_IDLE;
      tune_d  = TUNE_REST;
      last_d  = 1'b0;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_d  = '0;
            last_d  = 1'b0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          // last_q stands in for an end marker once the top address has played
          if (last_q || (entry_beats == END_BEATS)) begin
            last_d = 1'b0;
            tune_d = TUNE_REST;
            if (loop_en) begin
              addr_d  = '0;
              state_d = S_FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            tune_d   = entry_tune;
            strobe_d = 1'b1;
            tmr_load = 1'b1;
            state_d  = S_PLAY;
          end
        end
        S_PLAY: begin
          if (tmr_tc) begin
            tune_d     = TUNE_REST;
            tmr_load   = 1'b1;
            tmr_beats  = 8'd1;
            tmr_period = GAP_LD;
            state_d    = S_GAP;
          end
        end
        S_GAP: begin
          if (tmr_tc) begin
            if (addr_q == '1) begin
              last_d = 1'b1;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
            state_d = S_FETCH;
          end
        end
        default: begin
          state_d = S_IDLE;
          tune_d  = TUNE_REST;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      tune_q   <= TUNE_REST;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      tune_q   <= tune_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_tune_sequencer.sv
// tb/tb_tune_sequencer.sv - directed self-checking bench for tune_sequencer (BEAT_CYCLES=4, GAP_CYCLES=2)
module tb_tune_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;

  logic [7:0]  rom_addr;
  logic [15:0] rom_data = 16'h0;
  logic [7:0]  tune;
  logic        busy, note_strobe, done;

  logic [1:0]  rom_addr2;
  logic [15:0] rom_data2 = 16'h0;
  logic [7:0]  tune2;
  logic        busy2, note_strobe2, done2;

  logic [15:0] rom  [0:255];
  logic [15:0] rom2 [0:3];

  logic [7:0]  e_tune [0:63];
  logic        e_busy [0:63];
  logic        e_str  [0:63];
  logic        e_done [0:63];
  logic [7:0]  e_addr [0:63];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data  <= rom[rom_addr];
  always @(posedge clk) rom_data2 <= rom2[rom_addr2];

  tune_sequencer #(.ADDR_W(8), .BEAT_CYCLES(4), .GAP_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .tune(tune), .busy(busy),
    .note_strobe(note_strobe), .done(done)
  );

  tune_sequencer #(.ADDR_W(2), .BEAT_CYCLES(4), .GAP_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .tune(tune2), .busy(busy2),
    .note_strobe(note_strobe2), .done(done2)
  );

  task automatic chk(input string tag, input int cyc, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic exp_clear();
    for (int i = 0; i < 64; i++) begin
      e_tune[i] = 8'h00; e_busy[i] = 1'b0; e_str[i] = 1'b0; e_done[i] = 1'b0; e_addr[i] = 8'h00;
    end
  endtask

  task automatic set_tune(input int a, input int b, input logic [7:0] v);
    for (int i = a; i <= b; i++) e_tune[i] = v;
  endtask

  task automatic set_busy(input int a, input int b);
    for (int i = a; i <= b; i++) e_busy[i] = 1'b1;
  endtask

  task automatic set_addr(input int a, input int b, input logic [7:0] v);
    for (int i = a; i <= b; i++) e_addr[i] = v;
  endtask

  // Cycle 0 is the cycle in which start is sampled; cycles 1..n are checked against e_*.
  task automatic run(input string tag, input bit sel, input int n, input int stop_c, input int restart_c);
    if (sel) start2 = 1'b1; else start = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      start  = (c == restart_c) && !sel;
      start2 = (c == restart_c) && sel;
      stop   = (c == stop_c);
      chk({tag, "_tune"},   c, 16'(sel ? tune2 : tune), 16'(e_tune[c]));
      chk({tag, "_busy"},   c, 16'(sel ? busy2 : busy), 16'(e_busy[c]));
      chk({tag, "_strobe"}, c, 16'(sel ? note_strobe2 : note_strobe), 16'(e_str[c]));
      chk({tag, "_done"},   c, 16'(sel ? done2 : done), 16'(e_done[c]));
      chk({tag, "_addr"},   c, 16'(sel ? 8'(rom_addr2) : rom_addr), 16'(e_addr[c]));
    end
    start = 1'b0; start2 = 1'b0; stop = 1'b0;
  endtask

  task automatic exp_song_a();
    exp_clear();
    set_tune(3, 18, 8'h11);
    set_tune(23, 30, 8'h21);
    set_busy(1, 34);
    e_str[3] = 1'b1; e_str[23] = 1'b1;
    e_done[35] = 1'b1;
    set_addr(21, 32, 8'd1);
    set_addr(33, 40, 8'd2);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 4; i++) rom2[i] = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tune", 0, 16'(tune), 16'h0);
    chk("rst_busy", 0, 16'(busy), 16'h0);
    chk("rst_strobe", 0, 16'(note_strobe), 16'h0);
    chk("rst_done", 0, 16'(done), 16'h0);
    chk("rst_addr", 0, 16'(rom_addr), 16'h0);
    chk("rst_busy2", 0, 16'(busy2), 16'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic two-note song
    rom[0] = 16'h1104; rom[1] = 16'h2102; rom[2] = 16'h0000;
    exp_song_a();
    run("song", 1'b0, 40, 0, 0);

    // stop five cycles into the first note
    exp_clear();
    set_tune(3, 7, 8'h11);
    set_busy(1, 7);
    e_str[3] = 1'b1;
    run("stop", 1'b0, 12, 7, 0);

    // replay from address 0, with a start pulse mid-note that must be ignored
    exp_song_a();
    run("replay", 1'b0, 40, 0, 10);

    // leading timed rest
    rom[0] = 16'h0001; rom[1] = 16'h3501; rom[2] = 16'h0000;
    exp_clear();
    set_tune(11, 14, 8'h35);
    set_busy(1, 18);
    e_str[3] = 1'b1; e_str[11] = 1'b1;
    e_done[19] = 1'b1;
    set_addr(9, 16, 8'd1);
    set_addr(17, 30, 8'd2);
    run("rest", 1'b0, 30, 0, 0);

    // looping: end marker at LOAD 34 refetches address 0, 8'h11 back at 37
    rom[0] = 16'h1104; rom[1] = 16'h2102; rom[2] = 16'h0000;
    loop_en = 1'b1;
    exp_clear();
    set_tune(3, 18, 8'h11);
    set_tune(23, 30, 8'h21);
    set_tune(37, 45, 8'h11);
    set_busy(1, 45);
    e_str[3] = 1'b1; e_str[23] = 1'b1; e_str[37] = 1'b1;
    set_addr(21, 32, 8'd1);
    set_addr(33, 34, 8'd2);
    run("loop", 1'b0, 45, 0, 0);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    loop_en = 1'b0;
    chk("loop_stop_busy", 46, 16'(busy), 16'h0);
    chk("loop_stop_tune", 46, 16'(tune), 16'h0);
    chk("loop_stop_done", 46, 16'(done), 16'h0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      chk("startstop_busy", c, 16'(busy), 16'h0);
      chk("startstop_tune", c, 16'(tune), 16'h0);
    end

    // asynchronous reset while the second note plays
    exp_song_a();
    run("prerst", 1'b0, 24, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_tune", 24, 16'(tune), 16'h0);
    chk("midrst_busy", 24, 16'(busy), 16'h0);
    chk("midrst_strobe", 24, 16'(note_strobe), 16'h0);
    chk("midrst_done", 24, 16'(done), 16'h0);
    chk("midrst_addr", 24, 16'(rom_addr), 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      chk("postrst_busy", c, 16'(busy), 16'h0);
      chk("postrst_done", c, 16'(done), 16'h0);
    end

    // ADDR_W=2 with four notes: done follows the gap of entry 3 without wrapping
    rom2[0] = 16'h1101; rom2[1] = 16'h1201; rom2[2] = 16'h1301; rom2[3] = 16'h1401;
    exp_clear();
    set_tune(3, 6, 8'h11);
    set_tune(11, 14, 8'h12);
    set_tune(19, 22, 8'h13);
    set_tune(27, 30, 8'h14);
    set_busy(1, 34);
    e_str[3] = 1'b1; e_str[11] = 1'b1; e_str[19] = 1'b1; e_str[27] = 1'b1;
    e_done[35] = 1'b1;
    set_addr(9, 16, 8'd1);
    set_addr(17, 24, 8'd2);
    set_addr(25, 40, 8'd3);
    run("wrap", 1'b1, 40, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
